cdc_nff_sync_filt: RTL and testbench

Multi-bit, N-stage synchronizer with a per-bit stability filter and edge-pulse outputs. It is the parametrised successor of the team's fixed two-flop synchronizer. Each bit of an asynchronous, quasi-static input bus is independently synchronized into the `clk` domain, then debounced by a consecutive-cycle stability counter. The block sits at the boundary of every destination domain that samples level signals: interrupts, status lines, strap and pad inputs, and handshake request/ack levels.

---
 rtl/cdc_nff_sync_filt.sv | 109 ++++++++++
 tb/tb_cdc_nff_sync_filt.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cdc_nff_sync_filt.sv
// Per-bit N-flop synchronizer with stability filter and registered edge pulses.
// Filter is compiled in when CDC_SYNC_FILTER_EN is defined; otherwise dout_o is the last sync flop.
module cdc_nff_sync_filt #(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           SYNC_STAGES   = 2,
  parameter int unsigned           FILTER_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic [DATA_WIDTH-1:0] rise_o,
  output logic [DATA_WIDTH-1:0] fall_o,
  output logic                  change_o
);

  if (SYNC_STAGES < 2) begin : gen_bad_stages
    $error("SYNC_STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : gen_bad_filter
    $error("FILTER_CYCLES must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : gen_bad_width
    $error("DATA_WIDTH must be >= 1");
  end

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] rise_d, fall_d;
  logic [DATA_WIDTH-1:0] rise_q, fall_q;
  logic                  change_q;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VAL;
    end else begin
      sync_q[0] <= din_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef CDC_SYNC_FILTER_EN
  localparam int unsigned     CntW   = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

  logic [CntW-1:0]       cnt_q [DATA_WIDTH];
  logic [CntW-1:0]       cnt_d [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] dout_q;

  // Any cycle where sync agrees with dout clears the count: no partial credit.
  always_comb begin
    dout_d = dout_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != dout_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          dout_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout_q <= RESET_VAL;
      for (int i = 0; i < DATA_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      dout_q <= dout_d;
      for (int i = 0; i < DATA_WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign prev   = dout_q;
  assign dout_o = dout_q;
`else
  // Next value of the last stage is the stage before it, so pulses land with the level.
  assign dout_d = sync_q[SYNC_STAGES-2];
  assign prev   = sync;
  assign dout_o = sync;
`endif

  assign rise_d = dout_d & ~prev;
  assign fall_d = ~dout_d & prev;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= |(rise_d | fall_d);
    end
  end

  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_o = change_q;

endmodule

// File: tb/tb_cdc_nff_sync_filt.sv
// Scoreboard bench for cdc_nff_sync_filt; expected events are queued by stimulus, checked by monitor.
module tb_cdc_nff_sync_filt;

  localparam int unsigned S  = 2;
  localparam int unsigned F  = 4;
  localparam logic [7:0]  RV = 8'hA5;
`ifdef CDC_SYNC_FILTER_EN
  localparam int Lat = S + F;
`else
  localparam int Lat = S;
`endif

  typedef struct {
    int         at;
    logic [7:0] dout;
    logic [7:0] rise;
    logic [7:0] fall;
  } evt_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] din_i = RV;
  logic [7:0] dout_o, rise_o, fall_o;
  logic       change_o;

  int         cyc = 0;
  logic       rst_seen = 1'b0;
  logic [7:0] exp_dout = RV;
  evt_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  cdc_nff_sync_filt #(
    .DATA_WIDTH   (8),
    .SYNC_STAGES  (S),
    .FILTER_CYCLES(F),
    .RESET_VAL    (RV)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .din_i   (din_i),
    .dout_o  (dout_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .change_o(change_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rstn;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int at, input logic [7:0] d, input logic [7:0] r,
                      input logic [7:0] f);
    evt_t e;
    e.at   = at;
    e.dout = d;
    e.rise = r;
    e.fall = f;
    exp_q.push_back(e);
  endtask

  // Monitor: an event slot must show the queued pulses; every other cycle must be quiet.
  always @(negedge clk) begin
    evt_t e;
    if (!rst_seen) exp_dout = RV;
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missed_event at cycle %0d: got no pulse, expected rise %h fall %h at %0d",
               cyc, e.rise, e.fall, e.at);
    end
    if (rst_seen && exp_q.size() > 0 && exp_q[0].at == cyc) begin
      e = exp_q.pop_front();
      chk("evt_dout", dout_o, e.dout);
      chk("evt_rise", rise_o, e.rise);
      chk("evt_fall", fall_o, e.fall);
      chk("evt_change", {7'b0, change_o}, 8'h01);
      exp_dout = e.dout;
    end else begin
      chk("idle_dout", dout_o, exp_dout);
      chk("idle_rise", rise_o, 8'h00);
      chk("idle_fall", fall_o, 8'h00);
      chk("idle_change", {7'b0, change_o}, 8'h00);
    end
  end

  initial begin
    int c;
    int r;
    // Reset with input equal to reset value, then 20 quiet cycles.
    rstn  = 1'b0;
    din_i = RV;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);

    // Settle to zero: bits set in A5 fall together.
    din_i = 8'h00; c = cyc; push(c + Lat, 8'h00, 8'h00, 8'hA5);
    repeat (12) @(negedge clk);

    // Step bit 0.
    din_i = 8'h01; c = cyc; push(c + Lat, 8'h01, 8'h01, 8'h00);
    repeat (12) @(negedge clk);

    // 3-cycle glitch on bit 3.
    din_i = 8'h09; c = cyc;
`ifndef CDC_SYNC_FILTER_EN
    push(c + S, 8'h09, 8'h08, 8'h00);
    push(c + 3 + S, 8'h01, 8'h00, 8'h08);
`endif
    repeat (3) @(negedge clk);
    din_i = 8'h01;
    repeat (12) @(negedge clk);

    // Bounce on bit 5: high 3, low 1, then held high.
    din_i = 8'h21; c = cyc;
`ifdef CDC_SYNC_FILTER_EN
    push(c + 4 + Lat, 8'h21, 8'h20, 8'h00);
`else
    push(c + S, 8'h21, 8'h20, 8'h00);
    push(c + 3 + S, 8'h01, 8'h00, 8'h20);
    push(c + 4 + S, 8'h21, 8'h20, 8'h00);
`endif
    repeat (3) @(negedge clk);
    din_i = 8'h01;
    @(negedge clk);
    din_i = 8'h21;
    repeat (12) @(negedge clk);

    // All bits together.
    din_i = 8'h00; c = cyc; push(c + Lat, 8'h00, 8'h00, 8'h21);
    repeat (12) @(negedge clk);
    din_i = 8'hFF; c = cyc; push(c + Lat, 8'hFF, 8'hFF, 8'h00);
    repeat (12) @(negedge clk);
    din_i = 8'h00; c = cyc; push(c + Lat, 8'h00, 8'h00, 8'hFF);
    repeat (12) @(negedge clk);
    din_i = RV; c = cyc; push(c + Lat, RV, RV, 8'h00);
    repeat (12) @(negedge clk);

    // Reset while bit 2's count sits at 2; then re-qualify with full latency.
    din_i = 8'hA1; c = cyc;
`ifndef CDC_SYNC_FILTER_EN
    push(c + S, 8'hA1, 8'h00, 8'h04);
`endif
    repeat (S + 2) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1; r = cyc;
    push(r + Lat, 8'hA1, 8'h00, 8'h04);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 64 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      evt_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL pending_event: got none, expected rise %h fall %h at %0d",
               e.rise, e.fall, e.at);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
